hh_spike_detect: RTL and testbench
==================================

Name: hh_spike_detect

Overview:
- Downstream stage of the Hodgkin-Huxley neuron core.
- Consumes the signed Q9.5 membrane voltage stream, 14 bits wide.
- Detects action potentials with threshold hysteresis and a refractory window.
- Emits a one-cycle spike pulse and a running spike count; queues inter-spike-interval (ISI) events in a small FIFO with a valid/ready handshake toward the output or readout logic.

Parameters:
- W, 14: voltage width; signed two's complement, 5 fractional bits (Q9.5).
- TH_UP, 640: rising threshold in raw LSBs (+20.0 V units).
- TH_DN, -1280: re-arm level in raw LSBs (-40.0); TH_DN < TH_UP is required.
- REFRACT, 8: valid samples held in refractory after re-arm level is reached.
- ISI_W, 16: ISI and counter width.
- DEPTH, 4: event FIFO depth; power of two, at least 2.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- v_in, in, W: membrane voltage sample, signed Q9.5.
- v_valid, in, 1: v_in is a new sample this cycle.
- spike, out, 1: one-cycle pulse per detected spike.
- spike_count, out, ISI_W: total spikes since reset; saturates.
- armed, out, 1: high when the state is ARMED.
- evt_valid, out, 1: FIFO head valid.
- evt_ready, in, 1: consumer accepts the head.
- evt_isi, out, ISI_W: ISI of the head event, in samples.
- evt_peak, out, W: peak voltage of the head event (see Optional Feature).
- overflow, out, 1: sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release): state ARMED, all counters 0, FIFO empty, outputs 0.
  - Outputs therefore reset to: spike=0, spike_count=0, armed=1, evt_valid=0, evt_isi=0, evt_peak=0, overflow=0.
- All comparisons are signed. Logic advances only on cycles with v_valid=1. With v_valid=0, state and counters hold and spike=0.
- State machine:
  - ARMED -> HIGH when v_in >= TH_UP. A spike is detected on this sample.
  - HIGH -> REFR when v_in <= TH_DN. Refractory counter loads REFRACT-1.
  - REFR: decrement on each valid sample. At 0, go to ARMED on the next valid sample.
  - REFR with REFRACT=0: go directly HIGH -> ARMED.
  - Samples >= TH_UP in HIGH or REFR are ignored; no re-trigger.
- Spike output:
  - spike is registered and asserts the cycle after the detecting sample's edge.
  - spike_count increments with it and saturates at 2^ISI_W-1.
- ISI counter:
  - On each valid sample, isi_cnt <= isi_cnt+1, saturating at all-ones.
  - On the detecting sample, the event ISI = isi_cnt+1 (saturated) and isi_cnt clears to 0.
  - The first spike after reset reports the number of samples since reset, inclusive of the detecting sample.
- FIFO:
  - Push on the detecting edge, so the event is visible the same cycle spike is high.
  - Pop when evt_valid && evt_ready. evt_isi and evt_peak show the head and are stable while evt_valid=1 and evt_ready=0.
  - Full, push without pop: event dropped, overflow set (cleared only by reset). spike and spike_count still update.
  - Full, push with pop in the same cycle: both take effect; no drop.
  - Empty: evt_valid=0, evt_isi and evt_peak hold their last values.
- Reset mid-operation: a spike in progress, the FIFO contents and overflow are all discarded immediately.

Optional Feature:
Macro HH_SPIKE_PEAK_EN.
- Defined:
  - In HIGH, a peak register tracks max(v_in) over valid samples, loaded with v_in on the detecting sample.
  - The event is pushed on the HIGH -> REFR transition instead of on detection. It carries ISI (captured at detection) plus the peak.
  - spike timing is unchanged.
  - If reset occurs in HIGH, no event is pushed.
- Not defined: no peak register; evt_peak is tied to 0; push occurs at detection as described above.

Test Plan:
- Reset, then a flat v_in=-2080 (-65.0) for 100 valid samples -> spike=0, armed=1, evt_valid=0, spike_count=0.
- After reset, 9 samples of -2080, then 700 -> spike pulse one cycle later; evt_valid=1, evt_isi=10, spike_count=1.
- Pulses 700, 100, 700, -1300, then three samples of 700 while in REFR (REFRACT=8) -> exactly one spike; armed=0 until 8 valid samples after -1300, then armed=1.
- evt_ready=0; generate 5 spikes -> after the 4th, evt_valid stays 1 with head ISI unchanged; overflow=1 after the 5th; spike_count=5; draining yields exactly 4 events in order.
- FIFO full with evt_ready=1 on the same cycle as a new detection -> no drop, overflow stays 0, occupancy stays 4; v_valid toggling 1/0 gives ISI counted in valid samples only.
- With HH_SPIKE_PEAK_EN: sequence 700, 2000, 1500, -1300 -> one event with evt_peak=2000, pushed the cycle after the -1300 edge; assert rst_n mid-HIGH -> no event, evt_valid=0.

Source files
------------

// File: rtl/hh_spike_detect_if.sv
// ---------------------------------------------------------------------------
// hh_spike_detect_if
// Event stream from the spike detector's inter-spike-interval FIFO to the
// readout logic. Standard valid/ready handshake: the head entry is
// transferred on any cycle with evt_valid && evt_ready.
//   evt_valid : head entry present (driven by master)
//   evt_ready : consumer accepts the head (driven by slave)
//   evt_isi   : ISI of the head event in valid samples (driven by master)
//   evt_peak  : peak voltage of the head event, signed Q9.5 (driven by master)
// ---------------------------------------------------------------------------
interface hh_spike_detect_if #(
  parameter int W     = 14,
  parameter int ISI_W = 16
);
  logic                    evt_valid;
  logic                    evt_ready;
  logic        [ISI_W-1:0] evt_isi;
  logic signed [W-1:0]     evt_peak;

  modport master (output evt_valid, output evt_isi, output evt_peak, input evt_ready);
  modport slave  (input evt_valid, input evt_isi, input evt_peak, output evt_ready);
endinterface

// File: rtl/hh_spike_detect.sv
// ---------------------------------------------------------------------------
// hh_spike_detect
// Action-potential detector for the Hodgkin-Huxley neuron core. Watches the
// signed Q9.5 membrane voltage stream, fires on a rising threshold, re-arms
// after the voltage falls to the re-arm level and a refractory window has
// elapsed, and queues one inter-spike-interval event per spike.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   v_in/v_valid : voltage sample and its qualifier; logic advances only
//                  on cycles with v_valid=1
//   spike        : registered one-cycle pulse per detected spike
//   spike_count  : saturating spike total since reset
//   armed        : detector is waiting for a rising crossing
//   overflow     : sticky, an event was dropped on a full FIFO
//   evt          : event FIFO head (master side of hh_spike_detect_if)
//
// Optional feature, macro HH_SPIKE_PEAK_EN:
//   defined   - track the peak voltage while above threshold and push the
//               event when the voltage falls to the re-arm level, carrying
//               the ISI captured at detection plus the peak.
//   undefined - push at detection, evt_peak is constant 0.
// ---------------------------------------------------------------------------
module hh_spike_detect #(
  parameter int W       = 14,
  parameter int TH_UP   = 640,
  parameter int TH_DN   = -1280,
  parameter int REFRACT = 8,
  parameter int ISI_W   = 16,
  parameter int DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [W-1:0]     v_in,
  input  logic                    v_valid,
  output logic                    spike,
  output logic        [ISI_W-1:0] spike_count,
  output logic                    armed,
  output logic                    overflow,
  hh_spike_detect_if.master       evt
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int RCW = (REFRACT > 1) ? $clog2(REFRACT) : 1;

  localparam logic signed [W-1:0] TH_UP_V   = W'(TH_UP);
  localparam logic signed [W-1:0] TH_DN_V   = W'(TH_DN);
  localparam logic [RCW-1:0]      REFR_LOAD = RCW'((REFRACT > 0) ? REFRACT - 1 : 0);
  localparam logic [ISI_W-1:0]    ISI_MAX   = {ISI_W{1'b1}};
  localparam logic [CW-1:0]       FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_HIGH  = 2'd1,
    ST_REFR  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [RCW-1:0]   refr_cnt_r, refr_cnt_s;
  logic             detect_s;

  logic [ISI_W-1:0] isi_cnt_r, isi_inc_s, cnt_inc_s;
  logic             spike_r, overflow_r;
  logic [ISI_W-1:0] spike_count_r;

  logic             push_req_s, push_s, pop_s, drop_s;
  logic [ISI_W-1:0] push_isi_s;
  logic [ISI_W-1:0] mem_isi_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_ptr_s;
  logic [CW-1:0]    count_r, count_s, remain_s;
  logic             evt_valid_r;
  logic [ISI_W-1:0] evt_isi_r, head_isi_s;

  // Detector next-state: threshold hysteresis plus refractory countdown.
  always_comb begin
    state_s    = state_r;
    refr_cnt_s = refr_cnt_r;
    detect_s   = 1'b0;
    if (v_valid) begin
      case (state_r)
        ST_ARMED: begin
          if (v_in >= TH_UP_V) begin
            state_s  = ST_HIGH;
            detect_s = 1'b1;
          end else begin
            state_s  = ST_ARMED;
          end
        end
        ST_HIGH: begin
          if (v_in <= TH_DN_V) begin
            if (REFRACT == 0) begin
              state_s    = ST_ARMED;
            end else begin
              state_s    = ST_REFR;
              refr_cnt_s = REFR_LOAD;
            end
          end else begin
            state_s = ST_HIGH;
          end
        end
        ST_REFR: begin
          // Counter reaches 0 after REFRACT-1 samples; the next one re-arms.
          if (refr_cnt_r == {RCW{1'b0}}) begin
            state_s    = ST_ARMED;
          end else begin
            refr_cnt_s = refr_cnt_r - RCW'(1'b1);
          end
        end
        default: begin
          state_s = ST_ARMED;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Detector state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_ARMED;
      refr_cnt_r <= {RCW{1'b0}};
    end else begin
      state_r    <= state_s;
      refr_cnt_r <= refr_cnt_s;
    end
  end

  assign isi_inc_s = (isi_cnt_r == ISI_MAX) ? ISI_MAX : isi_cnt_r + ISI_W'(1'b1);
  assign cnt_inc_s = (spike_count_r == ISI_MAX) ? ISI_MAX : spike_count_r + ISI_W'(1'b1);

  // Spike pulse, saturating spike/ISI counters and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_r       <= 1'b0;
      spike_count_r <= {ISI_W{1'b0}};
      isi_cnt_r     <= {ISI_W{1'b0}};
      overflow_r    <= 1'b0;
    end else begin
      spike_r <= detect_s;
      if (detect_s) begin
        spike_count_r <= cnt_inc_s;
      end
      if (v_valid) begin
        isi_cnt_r <= detect_s ? {ISI_W{1'b0}} : isi_inc_s;
      end
      overflow_r <= overflow_r | drop_s;
    end
  end

  // FIFO control; a push into a full FIFO survives only if the head leaves
  // in the same cycle. Head registers reload from the post-update head so
  // they hold their last value once the FIFO drains.
  always_comb begin
    pop_s      = evt_valid_r & evt.evt_ready;
    push_s     = push_req_s & ((count_r != FULL_CNT) | pop_s);
    drop_s     = push_req_s & (count_r == FULL_CNT) & ~pop_s;
    count_s    = count_r + CW'(push_s) - CW'(pop_s);
    remain_s   = count_r - CW'(pop_s);
    rd_ptr_s   = rd_ptr_r + AW'(pop_s);
    head_isi_s = evt_isi_r;
    if (count_s == {CW{1'b0}}) begin
      head_isi_s = evt_isi_r;
    end else if (remain_s == {CW{1'b0}}) begin
      head_isi_s = push_isi_s;
    end else begin
      head_isi_s = mem_isi_r[rd_ptr_s];
    end
  end

  // FIFO ISI storage; contents are qualified by count_r, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_isi_r[wr_ptr_r] <= push_isi_s;
    end
  end

  // FIFO pointers, occupancy and registered head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      evt_valid_r <= 1'b0;
      evt_isi_r   <= {ISI_W{1'b0}};
    end else begin
      wr_ptr_r    <= wr_ptr_r + AW'(push_s);
      rd_ptr_r    <= rd_ptr_s;
      count_r     <= count_s;
      evt_valid_r <= (count_s != {CW{1'b0}});
      evt_isi_r   <= head_isi_s;
    end
  end

`ifdef HH_SPIKE_PEAK_EN
  logic signed [W-1:0] peak_r, evt_peak_r, head_peak_s;
  logic signed [W-1:0] mem_peak_r [DEPTH];
  logic [ISI_W-1:0]    isi_hold_r;
  logic                high_exit_s;

  // The event leaves HIGH together with its peak, so push on that exit.
  assign high_exit_s = v_valid & (state_r == ST_HIGH) & (v_in <= TH_DN_V);
  assign push_req_s  = high_exit_s;
  assign push_isi_s  = isi_hold_r;

  // Peak tracker and ISI capture for the event in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_r     <= {W{1'b0}};
      isi_hold_r <= {ISI_W{1'b0}};
    end else if (detect_s) begin
      peak_r     <= v_in;
      isi_hold_r <= isi_inc_s;
    end else if (v_valid && (state_r == ST_HIGH) && (v_in > peak_r)) begin
      peak_r     <= v_in;
    end
  end

  // Head peak selection mirrors the ISI head selection.
  always_comb begin
    head_peak_s = evt_peak_r;
    if (count_s == {CW{1'b0}}) begin
      head_peak_s = evt_peak_r;
    end else if (remain_s == {CW{1'b0}}) begin
      head_peak_s = peak_r;
    end else begin
      head_peak_s = mem_peak_r[rd_ptr_s];
    end
  end

  // FIFO peak storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_peak_r[wr_ptr_r] <= peak_r;
    end
  end

  // Registered head peak output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_peak_r <= {W{1'b0}};
    end else begin
      evt_peak_r <= head_peak_s;
    end
  end

  assign evt.evt_peak = evt_peak_r;
`else
  assign push_req_s   = detect_s;
  assign push_isi_s   = isi_inc_s;
  assign evt.evt_peak = {W{1'b0}};
`endif

  assign spike         = spike_r;
  assign spike_count   = spike_count_r;
  assign armed         = (state_r == ST_ARMED);
  assign overflow      = overflow_r;
  assign evt.evt_valid = evt_valid_r;
  assign evt.evt_isi   = evt_isi_r;

endmodule

// File: tb/tb_hh_spike_detect.sv
// ---------------------------------------------------------------------------
// tb_hh_spike_detect
// Directed bench for hh_spike_detect. A sample-level model (queue of events,
// integer counters) predicts every output after each clock; a negedge
// process compares DUT against it, and hand-computed literals pin the model.
// Build with HH_SPIKE_PEAK_EN to exercise the peak-tracking variant.
// ---------------------------------------------------------------------------
module tb_hh_spike_detect;
  localparam int W = 14, ISI_W = 16, DEPTH = 4, REFRACT = 8;
  localparam int TH_UP = 640, TH_DN = -1280, ISI_MAX = 65535;
`ifdef HH_SPIKE_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic signed [W-1:0]     v_in;
  logic                    v_valid;
  logic                    spike, armed, overflow;
  logic        [ISI_W-1:0] spike_count;

  hh_spike_detect_if #(.W(W), .ISI_W(ISI_W)) evt ();

  hh_spike_detect #(.W(W), .TH_UP(TH_UP), .TH_DN(TH_DN), .REFRACT(REFRACT),
                    .ISI_W(ISI_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .v_in(v_in), .v_valid(v_valid),
    .spike(spike), .spike_count(spike_count), .armed(armed),
    .overflow(overflow), .evt(evt)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  // Model: detector phase (0 armed, 1 above threshold, 2 refractory),
  // samples left in refractory, counters and the event queue.
  typedef struct { int isi; int peak; } ev_t;
  ev_t m_q[$];
  int  m_state, m_left, m_isi, m_cnt, m_ev_isi, m_peak, m_head_isi, m_head_peak;
  bit  m_spike, m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_left = 0; m_isi = 0; m_cnt = 0; m_ev_isi = 0; m_peak = 0;
    m_head_isi = 0; m_head_peak = 0; m_spike = 1'b0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  // Predict the outputs after one clock edge with the given inputs.
  task automatic model_step(input int v, input bit valid, input bit ready);
    bit   pop, det, hexit, push;
    int   nx;
    ev_t  e;
    pop = (m_q.size() != 0) && ready;
    det = 1'b0; hexit = 1'b0; push = 1'b0;
    m_spike = 1'b0;
    if (valid) begin
      nx = (m_isi >= ISI_MAX) ? ISI_MAX : m_isi + 1;
      if (m_state == 0) begin
        if (v >= TH_UP) begin det = 1'b1; m_state = 1; m_peak = v; m_ev_isi = nx; end
      end else if (m_state == 1) begin
        if (v > m_peak) m_peak = v;
        if (v <= TH_DN) begin hexit = 1'b1; m_left = REFRACT; m_state = (REFRACT == 0) ? 0 : 2; end
      end else begin
        m_left--;
        if (m_left == 0) m_state = 0;
      end
      m_isi = det ? 0 : nx;
      if (det) begin
        m_spike = 1'b1;
        if (m_cnt < ISI_MAX) m_cnt++;
      end
      push = PEAK ? hexit : det;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.isi = m_ev_isi;
      e.peak = PEAK ? m_peak : 0;
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else m_ovf = 1'b1;
    end
    if (m_q.size() != 0) begin
      m_head_isi = m_q[0].isi;
      m_head_peak = m_q[0].peak;
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("spike", int'(spike), int'(m_spike));
      chk("spike_count", int'(spike_count), m_cnt);
      chk("armed", int'(armed), int'(m_state == 0));
      chk("evt_valid", int'(evt.evt_valid), int'(m_q.size() != 0));
      chk("evt_isi", int'(evt.evt_isi), m_head_isi);
      chk("evt_peak", int'(evt.evt_peak), m_head_peak);
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic step(input int v, input bit valid, input bit ready);
    v_in = W'(v);
    v_valid = valid;
    evt.evt_ready = ready;
    @(posedge clk);
    #1;
    model_step(v, valid, ready);
  endtask

  task automatic async_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    v_valid = 1'b0;
    evt.evt_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  // One full spike: pre resting samples, rise, fall, refractory window.
  // gap inserts an invalid cycle after every valid filler sample.
  task automatic spike_seq(input int pre, input bit gap, input bit r_det, input bit r_exit);
    for (int i = 0; i < pre; i++) begin
      step(-2080, 1'b1, 1'b0);
      if (gap) step(-2080, 1'b0, 1'b0);
    end
    step(700, 1'b1, r_det);
    step(-1300, 1'b1, r_exit);
    for (int i = 0; i < REFRACT; i++) begin
      step(-2080, 1'b1, 1'b0);
      if (gap) step(-2080, 1'b0, 1'b0);
    end
  endtask

  task automatic drain(input int e0, input int e1, input int e2, input int e3);
    int got[$];
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 8 && evt.evt_valid; k++) begin
      got.push_back(int'(evt.evt_isi));
      step(-2080, 1'b0, 1'b1);
    end
    chk("drain_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("drain_isi", got[i], e[i]);
    chk("drain_empty", int'(evt.evt_valid), 0);
    chk("drain_hold_isi", int'(evt.evt_isi), e3);
  endtask

  initial begin
    v_in = '0;
    v_valid = 1'b0;
    evt.evt_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_spike", int'(spike), 0);
    chk("rst_count", int'(spike_count), 0);
    chk("rst_armed", int'(armed), 1);
    chk("rst_evt_valid", int'(evt.evt_valid), 0);
    chk("rst_evt_isi", int'(evt.evt_isi), 0);
    chk("rst_evt_peak", int'(evt.evt_peak), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Flat resting potential: nothing fires.
    repeat (100) step(-2080, 1'b1, 1'b1);
    chk("flat_count", int'(spike_count), 0);
    chk("flat_armed", int'(armed), 1);
    chk("flat_evt_valid", int'(evt.evt_valid), 0);

    // First spike ISI counts samples since reset inclusive.
    do_reset();
    repeat (9) step(-2080, 1'b1, 1'b0);
    step(700, 1'b1, 1'b0);
    chk("first_spike", int'(spike), 1);
    chk("first_evt_valid", int'(evt.evt_valid), PEAK ? 0 : 1);
    chk("first_evt_isi", int'(evt.evt_isi), PEAK ? 0 : 10);
    chk("first_count", int'(spike_count), 1);
    step(-2080, 1'b1, 1'b0);
    chk("spike_one_cycle", int'(spike), 0);

    // No re-trigger while high or refractory; re-arm after 8 valid samples.
    do_reset();
    step(700, 1'b1, 1'b0);
    step(100, 1'b1, 1'b0);
    step(700, 1'b0, 1'b0);
    step(700, 1'b1, 1'b0);
    step(-1300, 1'b1, 1'b0);
    chk("refr_armed_0", int'(armed), 0);
    repeat (3) step(700, 1'b1, 1'b0);
    step(-2080, 1'b0, 1'b0);
    repeat (4) step(-2080, 1'b1, 1'b0);
    chk("refr_armed_7", int'(armed), 0);
    step(-2080, 1'b1, 1'b0);
    chk("refr_armed_8", int'(armed), 1);
    chk("refr_count", int'(spike_count), 1);

    // Overflow: five spikes into a four-deep FIFO with no consumer.
    do_reset();
    spike_seq(1, 1'b0, 1'b0, 1'b0);
    spike_seq(2, 1'b0, 1'b0, 1'b0);
    spike_seq(3, 1'b0, 1'b0, 1'b0);
    spike_seq(4, 1'b0, 1'b0, 1'b0);
    chk("full_valid", int'(evt.evt_valid), 1);
    chk("full_head_isi", int'(evt.evt_isi), 2);
    chk("full_no_ovf", int'(overflow), 0);
    spike_seq(5, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(spike_count), 5);
    chk("ovf_head_isi", int'(evt.evt_isi), 2);
    drain(2, 12, 13, 14);
    spike_seq(1, 1'b0, 1'b0, 1'b0);
    async_reset();
    chk("midrst_evt_valid", int'(evt.evt_valid), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_count", int'(spike_count), 0);

    // Full FIFO with simultaneous pop and push; gapped valid samples.
    do_reset();
    spike_seq(1, 1'b0, 1'b0, 1'b0);
    spike_seq(2, 1'b0, 1'b0, 1'b0);
    spike_seq(3, 1'b0, 1'b0, 1'b0);
    spike_seq(4, 1'b0, 1'b0, 1'b0);
    spike_seq(5, 1'b1, !PEAK, PEAK);
    chk("pp_no_ovf", int'(overflow), 0);
    chk("pp_head_isi", int'(evt.evt_isi), 12);
    drain(12, 13, 14, 15);

`ifdef HH_SPIKE_PEAK_EN
    // Peak tracking and push on the falling edge.
    do_reset();
    step(700, 1'b1, 1'b0);
    step(2000, 1'b1, 1'b0);
    step(1500, 1'b1, 1'b0);
    chk("peak_not_yet", int'(evt.evt_valid), 0);
    step(-1300, 1'b1, 1'b0);
    chk("peak_valid", int'(evt.evt_valid), 1);
    chk("peak_value", int'(evt.evt_peak), 2000);
    chk("peak_isi", int'(evt.evt_isi), 1);
    // Reset while high discards the pending event.
    do_reset();
    step(700, 1'b1, 1'b0);
    step(900, 1'b1, 1'b0);
    async_reset();
    chk("peak_rst_valid", int'(evt.evt_valid), 0);
    do_reset();
    step(-1300, 1'b1, 1'b0);
    chk("peak_rst_no_evt", int'(evt.evt_valid), 0);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
